axis_stream_fifo: RTL and testbench

- Single-clock AXI4-Stream FIFO that buffers 64-bit beats together with their byte-enable (tkeep) and end-of-packet (tlast) sideband.
- Slave side accepts beats from an upstream producer; master side presents them in order to a downstream consumer.
- Sits between stream stages as an elastic buffer.
- Reports overflow and underflow handshake violations as single-cycle pulses.

---
 rtl/axis_stream_fifo.sv | 115 +++++++++++
 tb/tb_axis_stream_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_fifo.sv
// rtl/axis_stream_fifo.sv - single-clock AXI4-Stream FIFO with FWFT head, reset wait and handshake-violation pulses (optional AXIS_STREAM_FIFO_COUNT_EN)
module axis_stream_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 16,
    parameter int RESET_WAIT = 3
) (
    input  logic                  s_aclk,
    input  logic                  s_aresetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  axis_overflow,
    output logic                  axis_underflow
`ifdef AXIS_STREAM_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] axis_data_count
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int WAIT_W  = $clog2(RESET_WAIT + 1) + 1;

    // Entry layout: {tlast, tkeep, tdata}, stored untouched
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ready_en;
    logic              full;
    logic              wr_en;
    logic              rd_en;
    logic [ENTRY_W-1:0] head;

    assign full          = (count == CNT_W'(DEPTH));
    // Full blocks writes even when a read happens in the same cycle
    assign s_axis_tready = ready_en & ~full;
    assign m_axis_tvalid = (count != '0);
    assign wr_en         = s_axis_tvalid & s_axis_tready;
    assign rd_en         = m_axis_tvalid & m_axis_tready;

    // Head entry falls through combinationally; forced to zero when empty
    assign head          = mem[rd_ptr];
    assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? head[DATA_WIDTH +: KEEP_WIDTH] : '0;
    assign m_axis_tlast  = m_axis_tvalid & head[ENTRY_W-1];

`ifdef AXIS_STREAM_FIFO_COUNT_EN
    assign axis_data_count = count;
`endif

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge s_aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Post-reset wait: hold off tready for RESET_WAIT cycles after release
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            wait_cnt <= '0;
            ready_en <= 1'b0;
        end else if (!ready_en) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (32'(wait_cnt) + 32'd1 >= RESET_WAIT) begin
                ready_en <= 1'b1;
            end
        end
    end

    // Pointers and occupancy; simultaneous read and write leaves count unchanged
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Handshake violations as registered single-cycle pulses
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            axis_overflow  <= 1'b0;
            axis_underflow <= 1'b0;
        end else begin
            axis_overflow  <= s_axis_tvalid & ~s_axis_tready & ready_en;
            axis_underflow <= m_axis_tready & ~m_axis_tvalid;
        end
    end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb/tb_axis_stream_fifo.sv - directed self-checking bench for axis_stream_fifo
module tb_axis_stream_fifo;

    logic        s_aclk;
    logic        s_aresetn;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        axis_overflow;
    logic        axis_underflow;
`ifdef AXIS_STREAM_FIFO_COUNT_EN
    logic [4:0]  axis_data_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    axis_stream_fifo dut (
        .s_aclk         (s_aclk),
        .s_aresetn      (s_aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .axis_overflow  (axis_overflow),
        .axis_underflow (axis_underflow)
`ifdef AXIS_STREAM_FIFO_COUNT_EN
        ,
        .axis_data_count(axis_data_count)
`endif
    );

    initial s_aclk = 1'b0;
    always #5 s_aclk = ~s_aclk;

    task automatic step();
        @(posedge s_aclk);
        #1;
    endtask

    task automatic test_reset();
        s_aresetn     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 64'hDEAD_BEEF_0123_4567;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b1;
        m_axis_tready = 1'b0;
        step();
        step();
        total_cnt++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, axis_overflow, axis_underflow} !== '0)
            $display("FAIL reset_outputs: got tready=%b tvalid=%b tdata=%h tkeep=%h tlast=%b ovf=%b unf=%b, required all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, axis_overflow, axis_underflow);
        else pass_cnt++;
        s_aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (s_axis_tready !== 1'b0) $display("FAIL reset_wait_%0d: tready got %b required 0", i, s_axis_tready);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (s_axis_tready !== 1'b1) $display("FAIL reset_wait_done: tready got %b required 1", s_axis_tready);
        else pass_cnt++;
    endtask

    task automatic test_single_beat();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        s_axis_tkeep  = 8'hCF;
        s_axis_tlast  = 1'b1;
        m_axis_tready = 1'b1;
        total_cnt++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL single_pre_tvalid: got %b required 0", m_axis_tvalid);
        else pass_cnt++;
        step();
        s_axis_tvalid = 1'b0;
        total_cnt++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hCF, 1'b1})
            $display("FAIL single_head: got tvalid=%b tdata=%h tkeep=%h tlast=%b required 1/ffffffffffffffff/cf/1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        else pass_cnt++;
        step();
        m_axis_tready = 1'b0;
        total_cnt++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== '0)
            $display("FAIL single_after_read: got tvalid=%b tdata=%h tkeep=%h tlast=%b required all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        else pass_cnt++;
        step();
    endtask

    task automatic test_packet();
        logic [63:0] pkt [4];
        logic        flags;
        pkt[0] = 64'h1111_1111_1111_1111;
        pkt[1] = 64'h2222_2222_2222_2222;
        pkt[2] = 64'h3333_3333_3333_3333;
        pkt[3] = 64'h4444_4444_4444_4444;
        flags = 1'b0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pkt[i];
            s_axis_tkeep  = 8'hFF;
            s_axis_tlast  = (i == 3);
            step();
            flags = flags | axis_overflow | axis_underflow;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, pkt[i], 8'hFF, (i == 3)})
                $display("FAIL packet_beat_%0d: got tvalid=%b tdata=%h tkeep=%h tlast=%b required 1/%h/ff/%0d",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, pkt[i], (i == 3));
            else pass_cnt++;
            step();
            if (i == 3) m_axis_tready = 1'b0;
            flags = flags | axis_overflow | axis_underflow;
        end
        step();
        flags = flags | axis_overflow | axis_underflow;
        total_cnt++;
        if (flags !== 1'b0) $display("FAIL packet_no_violation: violation flag got %b required 0", flags);
        else pass_cnt++;
    endtask

    task automatic test_fill_overflow();
        bit ok;
        m_axis_tready = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 64'hA000_0000_0000_0000 + 64'(i);
            s_axis_tkeep  = 8'(i);
            s_axis_tlast  = i[0];
            if (s_axis_tready !== (i < 16)) begin
                $display("FAIL fill_tready_%0d: got %b required %0d", i, s_axis_tready, (i < 16));
                ok = 1'b0;
            end
            step();
        end
        total_cnt++;
        if (!ok) $display("FAIL fill_tready: tready sequence got error required 16 ready then 0");
        else pass_cnt++;
        s_axis_tvalid = 1'b0;
        total_cnt++;
        if (axis_overflow !== 1'b1) $display("FAIL overflow_pulse: got %b required 1", axis_overflow);
        else pass_cnt++;
        step();
        total_cnt++;
        if (axis_overflow !== 1'b0) $display("FAIL overflow_clear: got %b required 0", axis_overflow);
        else pass_cnt++;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, 64'hA000_0000_0000_0000 + 64'(i), 8'(i), i[0]})
                $display("FAIL drain_beat_%0d: got tvalid=%b tdata=%h tkeep=%h tlast=%b required 1/%h/%h/%b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                         64'hA000_0000_0000_0000 + 64'(i), 8'(i), i[0]);
            else pass_cnt++;
            step();
            if (i == 15) m_axis_tready = 1'b0;
        end
        total_cnt++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL drain_count: tvalid after 16 beats got %b required 0", m_axis_tvalid);
        else pass_cnt++;
        step();
    endtask

    task automatic test_underflow();
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        total_cnt++;
        if (axis_underflow !== 1'b1) $display("FAIL underflow_pulse: got %b required 1", axis_underflow);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({axis_underflow, m_axis_tvalid} !== 2'b00)
            $display("FAIL underflow_clear: got unf=%b tvalid=%b required 0/0", axis_underflow, m_axis_tvalid);
        else pass_cnt++;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'h0123_4567_89AB_CDEF;
        s_axis_tkeep  = 8'h0F;
        s_axis_tlast  = 1'b0;
        step();
        s_axis_tvalid = 1'b0;
        total_cnt++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0})
            $display("FAIL underflow_next_write: got tvalid=%b tdata=%h tkeep=%h tlast=%b required 1/0123456789abcdef/0f/0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        else pass_cnt++;
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        ok = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tkeep  = 8'hFF;
        for (int j = 0; j < 40; j++) begin
            s_axis_tdata = 64'hB0B0_0000_0000_0000 + 64'(j);
            s_axis_tlast = (j % 5 == 4);
            if (j > 0) begin
                if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready} !==
                    {1'b1, 64'hB0B0_0000_0000_0000 + 64'(j - 1), ((j - 1) % 5 == 4), 1'b1}) begin
                    $display("FAIL stream_beat_%0d: got tvalid=%b tdata=%h tlast=%b tready=%b required 1/%h/%0d/1",
                             j - 1, m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready,
                             64'hB0B0_0000_0000_0000 + 64'(j - 1), ((j - 1) % 5 == 4));
                    ok = 1'b0;
                end
`ifdef AXIS_STREAM_FIFO_COUNT_EN
                if (axis_data_count !== 5'd1) begin
                    $display("FAIL stream_count_%0d: got %0d required 1", j, axis_data_count);
                    ok = 1'b0;
                end
`endif
            end
            step();
        end
        total_cnt++;
        if (!ok) $display("FAIL stream_order: errors seen required in-order beats with steady occupancy");
        else pass_cnt++;
        total_cnt++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 64'hB0B0_0000_0000_0027})
            $display("FAIL stream_last_head: got tvalid=%b tdata=%h required 1/b0b0000000000027", m_axis_tvalid, m_axis_tdata);
        else pass_cnt++;
        s_aresetn = 1'b0;
        #1;
        total_cnt++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready} !== '0)
            $display("FAIL midreset_outputs: got tvalid=%b tdata=%h tkeep=%h tlast=%b tready=%b required all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready);
        else pass_cnt++;
        s_axis_tvalid = 1'b0;
        step();
        s_aresetn = 1'b1;
        step();
        step();
        total_cnt++;
        if (s_axis_tready !== 1'b0) $display("FAIL midreset_wait: tready got %b required 0", s_axis_tready);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({s_axis_tready, m_axis_tvalid} !== 2'b10)
            $display("FAIL midreset_empty: got tready=%b tvalid=%b required 1/0", s_axis_tready, m_axis_tvalid);
        else pass_cnt++;
        m_axis_tready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_packet();
        test_fill_overflow();
        test_underflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
